// File: rtl/pwm_pkg.sv
// Shared word types and single-step modular helpers for the PWM drive path.
// The word type is shared with the smoothing stage feeding this block.
package pwm_pkg;

  localparam int PWM_W = 13;

  typedef logic [PWM_W-1:0] pwm_word_t;
  typedef logic [PWM_W:0]   pwm_ext_t;

  // (a - b) mod cycle for a < cycle and b < cycle; one conditional add suffices.
  function automatic pwm_ext_t mod_sub(input pwm_ext_t a, input pwm_ext_t b, input pwm_ext_t cycle);
    return (a < b) ? (a - b + cycle) : (a - b);
  endfunction

  // (a + b) mod cycle for a < cycle and b <= cycle; one conditional subtract suffices.
  function automatic pwm_ext_t mod_add(input pwm_ext_t a, input pwm_ext_t b, input pwm_ext_t cycle);
    pwm_ext_t sum;
    sum = a + b;
    return (sum >= cycle) ? (sum - cycle) : sum;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period counter, double-buffered duty/phase, edge
// computation and a registered output compare.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] phase,
  output logic             pwm,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] pend_duty_r;
  logic [WIDTH-1:0] pend_phase_r;
  logic             pend_vld_r;
  logic [WIDTH-1:0] duty_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic             pwm_r;

  logic [WIDTH-1:0] cyc_m1_s;
  logic             wrap_s;
  logic             apply_s;
  logic [WIDTH-1:0] new_duty_s;
  logic [WIDTH-1:0] new_phase_s;
  logic [WIDTH-1:0] phase_red_s;
  logic [WIDTH-1:0] half_lo_s;
  logic [WIDTH-1:0] half_hi_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic             pwm_nxt_s;

  // A counter beyond cycle-1 (cycle shrunk) also wraps, so the boundary is >=.
  assign cyc_m1_s = cycle - WIDTH'(1);
  assign wrap_s   = (cnt_r >= cyc_m1_s);
  assign apply_s  = (wrap_s || sync) && (pend_vld_r || in_valid);

  // A strobe in the apply cycle bypasses the pending buffer.
  assign new_duty_s  = in_valid ? duty  : pend_duty_r;
  assign new_phase_s = in_valid ? phase : pend_phase_r;

  assign phase_red_s = (new_phase_s >= cycle) ? (new_phase_s - cycle) : new_phase_s;
  assign half_lo_s   = new_duty_s >> 1;
  assign half_hi_s   = new_duty_s - half_lo_s;
  assign rise_s      = WIDTH'(mod_sub(pwm_ext_t'(phase_red_s), pwm_ext_t'(half_lo_s), pwm_ext_t'(cycle)));
  assign fall_s      = WIDTH'(mod_add(pwm_ext_t'(phase_red_s), pwm_ext_t'(half_hi_s), pwm_ext_t'(cycle)));

  // Free-running period counter; sync has priority over the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (sync || wrap_s) begin
      cnt_r <= {WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_r + WIDTH'(1);
    end
  end

  // Pending buffer: last strobe before a boundary wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_duty_r  <= {WIDTH{1'b0}};
      pend_phase_r <= {WIDTH{1'b0}};
      pend_vld_r   <= 1'b0;
    end else if (apply_s) begin
      pend_vld_r   <= 1'b0;
    end else if (in_valid) begin
      pend_duty_r  <= duty;
      pend_phase_r <= phase;
      pend_vld_r   <= 1'b1;
    end
  end

  // Active duty and edges change only at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= {WIDTH{1'b0}};
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
    end else if (apply_s) begin
      duty_r <= new_duty_s;
      rise_r <= rise_s;
      fall_r <= fall_s;
    end
  end

  // Output decision for the current counter value.
  always_comb begin
    pwm_nxt_s = 1'b0;
    if (duty_r == {WIDTH{1'b0}}) begin
      pwm_nxt_s = 1'b0;
    end else if (duty_r >= cycle) begin
      pwm_nxt_s = 1'b1;
    end else if (rise_r < fall_r) begin
      pwm_nxt_s = (cnt_r >= rise_r) && (cnt_r < fall_r);
    end else begin
      pwm_nxt_s = (cnt_r >= rise_r) || (cnt_r < fall_r);
    end
  end

  // Registered drive bit, one clock behind the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= pwm_nxt_s;
    end
  end

  assign pwm = pwm_r;
  assign cnt = cnt_r;

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator: DEPTH independent channels sharing the
// sync pulse and the duty/phase strobe.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_W,
  parameter int DEPTH = 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        SYNC,
  input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
  input  logic [DEPTH-1:0][WIDTH-1:0] DUTY_S,
  input  logic [DEPTH-1:0][WIDTH-1:0] PHASE_S,
  input  logic                        IN_VALID,
  output logic [DEPTH-1:0]            PWM_OUT,
  output logic [DEPTH-1:0][WIDTH-1:0] CNT
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RST_N),
      .sync    (SYNC),
      .in_valid(IN_VALID),
      .cycle   (CYCLE[i]),
      .duty    (DUTY_S[i]),
      .phase   (PHASE_S[i]),
      .pwm     (PWM_OUT[i]),
      .cnt     (CNT[i])
    );
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Consumer end of the silent filter output. Takes the per-transducer smoothed duty and phase words (DUTY_S, PHASE_S, qualified by OUT_VALID) and produces one PWM drive bit per transducer.
- Each channel has a free-running period counter modulo CYCLE[i].
- New duty/phase values are double-buffered and applied only at a period boundary, so the output never glitches mid-period.
- Sits between silent and the transducer output pins, in the PWM clock domain.

Parameters:
- WIDTH, 13, bit width of the cycle, duty, phase and counter words.
- DEPTH, 1, number of transducer channels.

Ports:
- CLK  input  1  PWM clock (200 MHz); the only clock.
- RST_N  input  1  reset, asynchronous, active-low.
- SYNC  input  1  single-cycle pulse; forces every channel counter to 0 on the next edge.
- CYCLE  input  [WIDTH-1:0] x DEPTH  period per channel, in clocks; must be at least 2.
- DUTY_S  input  [WIDTH-1:0] x DEPTH  smoothed duty (high time in clocks).
- PHASE_S  input  [WIDTH-1:0] x DEPTH  smoothed phase (pulse centre, in clocks).
- IN_VALID  input  1  one-cycle strobe; DUTY_S/PHASE_S are valid in that cycle.
- PWM_OUT  output  [DEPTH-1:0]  drive bit per channel.
- CNT  output  [WIDTH-1:0] x DEPTH  current period counter per channel (debug and bench use).

Behaviour:
- Reset (RST_N low, asynchronous): all counters = 0; pending and active registers = 0; pending flag = 0; PWM_OUT = 0.
- Counter, per channel: t <= (t == CYCLE-1) ? 0 : t+1.
  - SYNC has priority over the wrap: t <= 0.
  - If CYCLE changes while t > CYCLE-1, the next edge sets t <= 0.
- Capture: on IN_VALID, DUTY_S/PHASE_S are latched into a pending register and the pending flag is set.
  - A later IN_VALID before the boundary overwrites pending (last value wins).
- Apply: in the cycle where t == CYCLE-1, or SYNC is high, with the pending flag set:
  - Pending values are copied to the active duty/phase registers.
  - rise and fall are recomputed.
  - The pending flag clears.
  - If IN_VALID coincides with the apply cycle, the new DUTY_S/PHASE_S are applied directly and the flag stays clear.
- Edge arithmetic, modulo CYCLE, done at WIDTH+1 bits and then reduced with a single conditional add/subtract of CYCLE:
  - rise = (PHASE - floor(DUTY/2)) mod CYCLE.
  - fall = (PHASE + ceil(DUTY/2)) mod CYCLE.
  - PHASE >= CYCLE is treated as PHASE - CYCLE.
- Output decision for counter value t:
  - DUTY == 0: low.
  - DUTY >= CYCLE: high.
  - rise < fall: high iff rise <= t < fall.
  - rise > fall (wrap): high iff t >= rise or t < fall.
  - rise == fall, with 0 < DUTY < CYCLE, cannot occur.
- Latency: PWM_OUT is registered. PWM_OUT at edge k reflects the counter value present before edge k, so it lags CNT by exactly 1 clock.
- Apply timing: active values take effect for the period that begins at t = 0. The first affected output sample is the one for t = 0.
- Channels are fully independent. Differing CYCLE[i] values are allowed.
- Deasserting reset mid-operation restarts all counters from 0 with duty 0 (output low) until the first apply.

Decomposition:
- Shared package pwm_pkg:
  - typedef of the WIDTH-bit word (shared with silent);
  - function mod_sub(a, b, cycle) and mod_add(a, b, cycle) for the single-step modular reduction.
- Sub-module pwm_channel: one counter, the pending/active registers, edge computation and output compare.
- pwm_gen instantiates DEPTH copies with a generate loop and fans out SYNC and IN_VALID.

Test Plan:
- Centred pulse: CYCLE=5000, DUTY=2500, PHASE=2500, IN_VALID once, then SYNC.
  - Rise=1250, fall=3750.
  - Over each following period, PWM_OUT is high for exactly 2500 clocks, rising one clock after CNT=1250.
- Wrap pulse: CYCLE=5000, DUTY=1000, PHASE=0.
  - High for CNT in [4500,4999] and [0,499]; 1000 high clocks per period.
  - Odd duty: DUTY=999, PHASE=0 gives rise=4501, fall=500, i.e. 999 high clocks.
- Extremes, with CYCLE=5000:
  - DUTY=0 gives PWM_OUT constantly 0.
  - DUTY=5000 or DUTY=8191 gives constantly 1, across at least 3 periods.
- Mid-period update: active DUTY=2500/PHASE=2500; at CNT=2000 pulse IN_VALID with DUTY=500, PHASE=1000.
  - Current period is unchanged (still falls after CNT=3750).
  - Next period is high only for CNT in [750,1249].
  - Two IN_VALIDs in one period: only the last one applies.
- SYNC and coincidence: pulse SYNC at CNT=3000 with a pending update.
  - CNT returns to 0 and the update is applied immediately.
  - IN_VALID in the same cycle as the CNT=4999 wrap applies that same cycle's values at t=0.
- Reset mid-operation: assert RST_N low at CNT=1234 for 3 clocks.
  - PWM_OUT = 0 and CNT = 0 immediately (asynchronous).
  - After release, CNT counts from 0 and PWM_OUT stays 0 until the next IN_VALID is applied.
- Multi-channel: DEPTH=4, CYCLE={5000,4000,5000,2500}, random DUTY_S/PHASE_S.
  - A bench reference model compares PWM_OUT bit-exact per channel for 10 periods.
